spi_slave_mem: RTL and testbench

SPI_SLAVE_MEM -- requirements
Module: spi_slave_mem

---
 rtl/spi_slave_mem.sv | 129 ++++++++++++
 tb/tb_spi_slave_mem.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem.sv
// SPI-style slave fronting a 32x8 register file: one bit per clk, LSB first,
// 7-bit header {A[4:0], INC, RW}, then data bytes; host side has a registered read port.
module spi_slave_mem #(
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [4:0] host_rd_addr,
  output logic [7:0] host_rd_data,
  output logic       wr_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StHdr, StByte, StWaitCs} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_mem [32];
  logic [5:0] r_hdr;
  logic [2:0] r_bit_cnt;
  logic [4:0] r_addr;
  logic [7:0] r_sh;
  logic       r_miso, r_wr_done, r_frame_err;
  logic [7:0] r_host;

  logic       w_rw, w_inc;
  logic       w_commit, w_abort, w_adv, w_load, w_shift;
  logic [4:0] w_new_addr;
  logic [7:0] w_wdata, w_rdata;

  // Header bits shift in from the top, so by cycle 6 r_hdr[k] holds header bit k.
  assign w_rw    = r_hdr[0];
  assign w_inc   = r_hdr[1];
  assign w_wdata = {MOSI, r_sh[7:1]};
  assign w_rdata = r_mem[w_new_addr];
  assign w_load  = w_adv & ~w_rw;

  always_comb begin
    w_state_d  = r_state;
    w_commit   = 1'b0;
    w_abort    = 1'b0;
    w_adv      = 1'b0;
    w_shift    = 1'b0;
    w_new_addr = r_addr + 5'd1;
    case (r_state)
      StIdle: begin
        if (!CS) w_state_d = StHdr;
      end
      StHdr: begin
        if (CS) begin
          w_state_d = StIdle;
          w_abort   = 1'b1;
        end else if (r_bit_cnt == 3'd6) begin
          w_state_d  = StByte;
          w_adv      = 1'b1;
          w_new_addr = {MOSI, r_hdr[5:2]};
        end
      end
      StByte: begin
        if (r_bit_cnt == 3'd7) begin
          // CS rising on the last bit still completes the byte.
          w_commit = w_rw;
          if (CS)         w_state_d = StIdle;
          else if (w_inc) w_adv     = 1'b1;
          else            w_state_d = StWaitCs;
        end else if (CS) begin
          w_state_d = StIdle;
          w_abort   = 1'b1;
        end else begin
          w_shift = 1'b1;
        end
      end
      StWaitCs: begin
        if (CS) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_hdr       <= '0;
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_sh        <= '0;
      r_miso      <= 1'b0;
      r_wr_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_host      <= '0;
      for (int i = 0; i < 32; i++) r_mem[i] <= MEM_INIT;
    end else begin
      r_state     <= w_state_d;
      r_wr_done   <= w_commit;
      r_frame_err <= w_abort;
      r_miso      <= 1'b0;

      if (r_state == StIdle) r_hdr <= {MOSI, 5'b0};
      else if (r_state == StHdr && r_bit_cnt != 3'd6) r_hdr <= {MOSI, r_hdr[5:1]};

      if (w_state_d == StHdr || w_state_d == StByte)
        r_bit_cnt <= (r_state == StHdr && r_bit_cnt == 3'd6) ? 3'd0 : r_bit_cnt + 3'd1;
      else
        r_bit_cnt <= 3'd0;

      if (w_adv) r_addr <= w_new_addr;

      // One shift register serves both directions: read data out, write data in.
      if (w_load) begin
        r_sh   <= {1'b0, w_rdata[7:1]};
        r_miso <= w_rdata[0];
      end else if (w_shift) begin
        r_sh   <= {w_rw & MOSI, r_sh[7:1]};
        r_miso <= ~w_rw & r_sh[0];
      end

      if (w_commit) r_mem[r_addr] <= w_wdata;
      r_host <= (w_commit && r_addr == host_rd_addr) ? w_wdata : r_mem[host_rd_addr];
    end
  end

  assign MISO         = r_miso;
  assign wr_done      = r_wr_done;
  assign frame_err    = r_frame_err;
  assign host_rd_data = r_host;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench for spi_slave_mem: write, read, incrementing bursts with wrap,
// mid-byte abort and mid-frame reset.
module tb_spi_slave_mem;

  localparam logic [7:0] INIT = 8'h3C;

  logic       clk = 1'b0;
  logic       rst, CS, MOSI, MISO;
  logic [4:0] host_rd_addr;
  logic [7:0] host_rd_data;
  logic       wr_done, frame_err;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  spi_slave_mem #(.MEM_INIT(INIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .CS           (CS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .wr_done      (wr_done),
    .frame_err    (frame_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic cs_hi);
    MOSI = b;
    CS   = cs_hi;
    tick();
  endtask

  task automatic idle_cycle();
    MOSI = 1'b0;
    CS   = 1'b1;
    tick();
  endtask

  task automatic send_hdr(input logic rw, input logic inc, input logic [4:0] a);
    logic [6:0] h;
    h = {a, inc, rw};
    for (int k = 0; k < 7; k++) begin
      chk("miso_hdr", MISO, 8'h00);
      send_bit(h[k], 1'b0);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    for (int k = 0; k < 8; k++) begin
      chk("miso_wr", MISO, 8'h00);
      send_bit(d[k], last && k == 7);
    end
    chk("wr_done_pulse", wr_done, 8'h01);
    chk("no_frame_err", frame_err, 8'h00);
  endtask

  task automatic read_byte(input logic [7:0] d, input logic last);
    for (int k = 0; k < 8; k++) begin
      chk("miso_rd", MISO, {7'b0, d[k]});
      send_bit(1'b0, last && k == 7);
    end
  endtask

  task automatic host_chk(input logic [4:0] a, input logic [7:0] exp);
    host_rd_addr = a;
    tick();
    chk("host_rd", host_rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; CS = 1'b1; MOSI = 1'b0; host_rd_addr = '0;
    tick();
    tick();
    chk("rst_miso", MISO, 8'h00);
    chk("rst_wr_done", wr_done, 8'h00);
    chk("rst_frame_err", frame_err, 8'h00);
    chk("rst_host", host_rd_data, 8'h00);
    rst = 1'b0;
    idle_cycle();

    // Single write A=5, data A5, frame ends via WAIT_CS
    send_hdr(1'b1, 1'b0, 5'd5);
    write_byte(8'hA5, 1'b0);
    idle_cycle();
    chk("wr_done_single", wr_done, 8'h00);
    host_chk(5'd5, 8'hA5);

    // Single read A=5
    send_hdr(1'b0, 1'b0, 5'd5);
    read_byte(8'hA5, 1'b0);
    chk("miso_wait_cs", MISO, 8'h00);
    idle_cycle();
    chk("miso_after_cs", MISO, 8'h00);

    // Incrementing write from 30 wraps to 0; CS rises with last bit
    send_hdr(1'b1, 1'b1, 5'd30);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    write_byte(8'h33, 1'b1);
    host_chk(5'd30, 8'h11);
    host_chk(5'd31, 8'h22);
    host_chk(5'd0, 8'h33);

    // Incrementing read back-to-back
    send_hdr(1'b0, 1'b1, 5'd30);
    read_byte(8'h11, 1'b0);
    read_byte(8'h22, 1'b0);
    read_byte(8'h33, 1'b1);
    chk("miso_after_burst", MISO, 8'h00);
    chk("burst_no_err", frame_err, 8'h00);

    // Abort after byte bit 4
    host_chk(5'd3, INIT);
    send_hdr(1'b1, 1'b0, 5'd3);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("abort_frame_err", frame_err, 8'h01);
    chk("abort_no_wr", wr_done, 8'h00);
    chk("abort_miso", MISO, 8'h00);
    idle_cycle();
    chk("abort_err_once", frame_err, 8'h00);
    host_chk(5'd3, INIT);
    send_hdr(1'b1, 1'b0, 5'd3);
    write_byte(8'h5A, 1'b1);
    host_chk(5'd3, 8'h5A);

    // Reset in the middle of a write byte
    send_hdr(1'b1, 1'b0, 5'd7);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    rst = 1'b1; CS = 1'b1; MOSI = 1'b0;
    tick();
    chk("midrst_miso", MISO, 8'h00);
    chk("midrst_wr_done", wr_done, 8'h00);
    chk("midrst_frame_err", frame_err, 8'h00);
    chk("midrst_host", host_rd_data, 8'h00);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) host_chk(a[4:0], INIT);
    send_hdr(1'b0, 1'b0, 5'd0);
    read_byte(INIT, 1'b1);
    chk("final_miso", MISO, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
